// File: rtl/csb_to_periph.sv
// CSB register-bus responder bridged onto an HWPE periph initiator, one transaction in flight.
// Optional per-transaction timeout is enabled by defining CSB_TO_PERIPH_TIMEOUT_EN.
module csb_to_periph #(
  parameter int          ID_WIDTH  = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          TIMEOUT   = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  // CSB responder
  input  logic                csb_valid,
  output logic                csb_ready,
  input  logic [15:0]         csb_addr,
  input  logic [31:0]         csb_wdat,
  input  logic                csb_write,
  input  logic                csb_nposted,
  output logic                csb_r_valid,
  output logic [31:0]         csb_r_data,
  output logic                csb_wr_complete,
  // HWPE periph initiator
  output logic                periph_req,
  input  logic                periph_gnt,
  output logic [31:0]         periph_add,
  output logic                periph_wen,
  output logic [3:0]          periph_be,
  output logic [31:0]         periph_data,
  output logic [ID_WIDTH-1:0] periph_id,
  input  logic                periph_r_valid,
  input  logic [31:0]         periph_r_data,
  input  logic [ID_WIDTH-1:0] periph_r_id,
  // FSM state for observation: 0 IDLE, 1 REQ, 2 WAIT, 3 RESP
  output logic [1:0]          o_dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  // Handshakes: a CSB request is taken on a rising edge where csb_valid && csb_ready;
  // a periph request is taken on a rising edge where periph_req && periph_gnt; a periph
  // response counts only when periph_r_valid and periph_r_id equals the outstanding tag.

  logic [1:0]          r_state;
  logic [15:0]         r_addr;
  logic [31:0]         r_wdat;
  logic                r_write;
  logic                r_nposted;
  logic [ID_WIDTH-1:0] r_tag;
  logic [ID_WIDTH-1:0] r_id;
  logic [31:0]         r_rdata;

  logic w_match;
  logic w_timeout;
  logic w_req;

  assign w_match = periph_r_valid && (periph_r_id == r_id);

`ifdef CSB_TO_PERIPH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;

  assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      r_cnt <= '0;
    end else if ((r_state == S_REQ) || (r_state == S_WAIT)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_wdat    <= '0;
      r_write   <= 1'b0;
      r_nposted <= 1'b0;
      r_tag     <= '0;
      r_id      <= '0;
      r_rdata   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (csb_valid) begin
            r_addr    <= csb_addr;
            r_wdat    <= csb_wdat;
            r_write   <= csb_write;
            r_nposted <= csb_nposted;
            r_id      <= r_tag;
            r_tag     <= r_tag + ID_WIDTH'(1);
            r_state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (periph_gnt && w_match) begin
            if (!r_write) r_rdata <= periph_r_data;
            r_state <= S_RESP;
          end else if (w_timeout) begin
            r_rdata <= 32'hDEAD_BEEF;
            r_state <= S_RESP;
          end else if (periph_gnt) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_match) begin
            if (!r_write) r_rdata <= periph_r_data;
            r_state <= S_RESP;
          end else if (w_timeout) begin
            r_rdata <= 32'hDEAD_BEEF;
            r_state <= S_RESP;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Periph fields are gated by REQ so they read zero whenever no request is offered.
  assign w_req           = (r_state == S_REQ);
  assign periph_req      = w_req;
  assign periph_add      = w_req ? {BASE_ADDR[31:16], r_addr} : 32'h0;
  assign periph_wen      = w_req & ~r_write;
  assign periph_be       = w_req ? 4'hF : 4'h0;
  assign periph_data     = w_req ? r_wdat : 32'h0;
  assign periph_id       = w_req ? r_id : '0;

  assign csb_ready       = rst_n && (r_state == S_IDLE);
  assign csb_r_valid     = (r_state == S_RESP) && !r_write;
  assign csb_wr_complete = (r_state == S_RESP) && r_write && r_nposted;
  assign csb_r_data      = r_rdata;
  assign o_dbg_state     = r_state;

endmodule
